game_tick_scheduler: RTL
========================

Name: game_tick_scheduler

Overview:
Consumes the single-cycle game tick pulse from the game clock divider and turns it into paced game-step requests for the game logic. Ticks are prescaled by SUBDIV, and steps the logic has not yet served are queued in a saturating pending counter. Each step is handed to the logic over a four-phase req/ack handshake. The block reports completed frames and a sticky overrun flag when the logic falls behind.

Parameters:
SUBDIV, 10, tick pulses per game step (≥1; 1 means every tick is a step)
MAX_PENDING, 3, maximum queued steps (1..15)
FRAME_W, 16, width of frame_count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tick_in  input  1  one-cycle tick pulse from the divider, synchronous to clk
pause  input  1  level; freezes prescaler and ignores ticks
step_ack  input  1  game logic acknowledge (four-phase)
clear_overrun  input  1  one-cycle pulse; clears overrun
step_req  output  1  step request to game logic
frame_count  output  FRAME_W  completed steps, wraps modulo 2^FRAME_W
pending  output  4  queued steps not yet acknowledged
overrun  output  1  sticky: a step event was dropped

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, pending=0, frame_count=0, overrun=0, step_req=0, FSM=IDLE.
- Prescaler:
  - On tick_in=1 with pause=0: if prescaler==SUBDIV-1, it returns to 0 and a step event is raised in the same cycle; otherwise it increments.
  - pause=1: prescaler holds and tick_in is ignored. There is no catch-up after pause.
- Pending counter update, per cycle:
  - step event only: pending+1 if pending<MAX_PENDING; otherwise pending holds and overrun←1.
  - ack capture only (FSM REQ→ACKD transition): pending−1.
  - both in the same cycle: pending unchanged; no overrun, even when pending==MAX_PENDING.
- FSM:
  - IDLE: step_req=0. If pending>0, go to REQ; step_req is registered high the next cycle.
  - REQ: step_req=1. On step_ack=1: go to ACKD, drop step_req the next cycle, decrement pending, and increment frame_count (wrap 2^FRAME_W−1→0).
  - ACKD: step_req=0. Wait for step_ack=0, then go to IDLE.
- Latency and handshake rules:
  - Minimum latency from the step-event cycle to step_req=1 is 2 clk edges: pending update, then FSM.
  - step_ack=1 seen in IDLE or ACKD is ignored; it does not count.
  - pause does not affect the FSM. An in-flight handshake completes, and queued steps continue to drain while paused.
- overrun: set as above, cleared by clear_overrun. A set and a clear in the same cycle leaves overrun=1 (set wins).
- Reset mid-handshake: step_req drops immediately (asynchronous) and the queue is lost. Game logic must tolerate its ack being abandoned.
- All outputs are registered.

Test Plan:
1. SUBDIV=10, pause=0, tick every 5 clk, ack responds 2 clk after req → first step_req rises 2 clk after the 10th tick; after 3 handshakes frame_count=3, pending=0, overrun=0.
2. SUBDIV=1, hold step_ack=0, 5 ticks → pending goes 1,2,3,3,3; overrun=1 on the 4th tick; step_req stays 1. Then clear_overrun → overrun=0. Release acks → pending drains 3→0 over 3 full handshakes.
3. pending=3 (MAX); a step event coincides with the REQ→ACKD ack cycle → pending stays 3, overrun stays 0.
4. pause=1 after 7 of 10 ticks, 20 ticks during pause, pause=0, 3 more ticks → exactly one step event, on the 3rd post-pause tick.
5. Assert rst=0 while in REQ with pending=2 → step_req=0, pending=0, frame_count=0 without a clk edge. Release rst → FSM is in IDLE and no req appears until a new step event.
6. frame_count preset near wrap via 2^16 handshakes (or FRAME_W=4 build: 16 handshakes) → rolls to 0, no other side effect; a spurious step_ack pulse in IDLE leaves frame_count and pending unchanged.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Turns prescaled game ticks into queued step requests served over a four-phase
// req/ack handshake. Also counts completed frames and flags dropped steps.
module game_tick_scheduler #(
   parameter int SUBDIV      = 10,
   parameter int MAX_PENDING = 3,
   parameter int FRAME_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_in,
   input  logic               pause,
   input  logic               step_ack,
   input  logic               clear_overrun,
   output logic               step_req,
   output logic [FRAME_W-1:0] frame_count,
   output logic [3:0]         pending,
   output logic               overrun
);

   localparam int            PW         = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SUBDIV - 1);
   localparam logic [3:0]    PEND_MAX   = 4'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACKD = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [PW-1:0]      presc_reg, presc_next;
   logic [3:0]         pending_reg, pending_next;
   logic [FRAME_W-1:0] frame_reg, frame_next;
   logic               overrun_reg, overrun_next;
   logic               step_req_reg, step_req_next;
   logic               step_event;
   logic               ack_capture;
   logic               overrun_set;

   // Prescaler: paused ticks are simply lost, never replayed.
   always_comb begin
      presc_next = presc_reg;
      step_event = 1'b0;
      if (tick_in && !pause) begin
         if (presc_reg == PRESC_LAST) begin
            presc_next = '0;
            step_event = 1'b1;
         end else begin
            presc_next = presc_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      ack_capture = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pending_reg != 4'd0) state_next = REQ;
         end
         REQ: begin
            if (step_ack) begin
               state_next  = ACKD;
               ack_capture = 1'b1;
            end
         end
         ACKD: begin
            if (!step_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      step_req_next = (state_next == REQ);
   end

   // A simultaneous event and ack cancel out, so a full queue cannot overrun then.
   always_comb begin
      pending_next = pending_reg;
      overrun_set  = 1'b0;
      if (step_event && !ack_capture) begin
         if (pending_reg < PEND_MAX) pending_next = pending_reg + 1'b1;
         else                        overrun_set  = 1'b1;
      end else if (ack_capture && !step_event) begin
         pending_next = pending_reg - 1'b1;
      end
      overrun_next = overrun_set ? 1'b1 : (clear_overrun ? 1'b0 : overrun_reg);
      frame_next   = ack_capture ? frame_reg + 1'b1 : frame_reg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         presc_reg    <= '0;
         pending_reg  <= 4'd0;
         frame_reg    <= '0;
         overrun_reg  <= 1'b0;
         step_req_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         presc_reg    <= presc_next;
         pending_reg  <= pending_next;
         frame_reg    <= frame_next;
         overrun_reg  <= overrun_next;
         step_req_reg <= step_req_next;
      end
   end

   assign step_req    = step_req_reg;
   assign frame_count = frame_reg;
   assign pending     = pending_reg;
   assign overrun     = overrun_reg;

endmodule
